// File: rtl/eth_idma_desc_queue.sv
// Descriptor FIFO and issue/retire controller for the Ethernet iDMA backend.
// Queues descriptors, limits requests in flight, counts completions and raises frame interrupts.
module eth_idma_desc_queue #(
    parameter int         AddrWidth      = 32,
    parameter int         TFLenWidth     = 32,
    parameter int         QueueDepth     = 4,
    parameter int         MaxOutstanding = 2,
    parameter logic [2:0] ProtoAxi       = 3'd0,
    parameter logic [2:0] ProtoAxis      = 3'd7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    input  logic [AddrWidth-1:0]  desc_src_addr_i,
    input  logic [AddrWidth-1:0]  desc_dst_addr_i,
    input  logic [TFLenWidth-1:0] desc_length_i,
    input  logic                  desc_dir_i,
    input  logic                  desc_last_i,
    input  logic                  flush_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [AddrWidth-1:0]  req_src_addr_o,
    output logic [AddrWidth-1:0]  req_dst_addr_o,
    output logic [TFLenWidth-1:0] req_length_o,
    output logic [2:0]            req_src_protocol_o,
    output logic [2:0]            req_dst_protocol_o,
    output logic                  req_last_o,
    input  logic                  rsp_valid_i,
    output logic                  rsp_ready_o,
    input  logic                  rsp_error_i,
    output logic                  busy_o,
    output logic [15:0]           done_cnt_o,
    output logic [7:0]            err_cnt_o,
    output logic                  zero_drop_o,
    output logic                  irq_o
);

    localparam int IdxW = $clog2(QueueDepth);
    localparam int PtrW = IdxW + 1;
    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam int TagW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int EntW = 2 * AddrWidth + TFLenWidth + 2;

    logic [EntW-1:0]           mem_q [QueueDepth];
    logic [QueueDepth-1:0]     mem_we;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OutW-1:0]           out_q, out_d;
    logic [MaxOutstanding-1:0] tag_q;
    logic [TagW-1:0]           tag_wr_q, tag_rd_q;
    logic [15:0]               done_q;
    logic [7:0]                err_q;
    logic                      zero_q, irq_q;

    logic                      empty, full, push_hs, store, issue, retire, head_dir;
    logic [EntW-1:0]           head;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

    assign desc_ready_o = !full && !flush_i;
    assign push_hs      = desc_valid_i && desc_ready_o;
    // Zero-length descriptors complete the handshake but never occupy a slot.
    assign store        = push_hs && (desc_length_i != '0);

    assign req_valid_o  = !empty && (out_q < OutW'(MaxOutstanding));
    assign issue        = req_valid_o && req_ready_i;
    assign rsp_ready_o  = (out_q != '0);
    assign retire       = rsp_valid_i && rsp_ready_o;
    assign busy_o       = !empty || (out_q != '0);

    assign head = mem_q[rd_ptr_q[IdxW-1:0]];
    assign {req_src_addr_o, req_dst_addr_o, req_length_o, head_dir, req_last_o} = head;
    assign req_src_protocol_o = head_dir ? ProtoAxis : ProtoAxi;
    assign req_dst_protocol_o = head_dir ? ProtoAxi  : ProtoAxis;

    generate
        for (genvar gi = 0; gi < QueueDepth; gi++) begin : g_we
            assign mem_we[gi] = store && (wr_ptr_q[IdxW-1:0] == IdxW'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q;
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        // A presented head survives a flush so the request stays stable until accepted.
        if (flush_i) begin
            wr_ptr_d = req_valid_o ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        end else if (store) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        case ({issue, retire})
            2'b10:   out_d = out_q + OutW'(1);
            2'b01:   out_d = out_q - OutW'(1);
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < QueueDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            out_q    <= '0;
            tag_q    <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
            zero_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            for (int i = 0; i < QueueDepth; i++) begin
                if (mem_we[i]) begin
                    mem_q[i] <= {desc_src_addr_i, desc_dst_addr_i, desc_length_i,
                                 desc_dir_i, desc_last_i};
                end
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            out_q    <= out_d;
            if (issue) begin
                tag_q[tag_wr_q] <= req_last_o;
                tag_wr_q <= (tag_wr_q == TagW'(MaxOutstanding - 1)) ? '0 : tag_wr_q + TagW'(1);
            end
            if (retire) begin
                tag_rd_q <= (tag_rd_q == TagW'(MaxOutstanding - 1)) ? '0 : tag_rd_q + TagW'(1);
                if (rsp_error_i) begin
                    if (err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                end else begin
                    done_q <= done_q + 16'd1;
                end
            end
            irq_q <= retire && (tag_q[tag_rd_q] || rsp_error_i);
            if (push_hs && (desc_length_i == '0)) begin
                zero_q <= 1'b1;
            end
        end
    end

    assign done_cnt_o  = done_q;
    assign err_cnt_o   = err_q;
    assign zero_drop_o = zero_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_eth_idma_desc_queue.sv
// Scoreboard bench for eth_idma_desc_queue: a negedge monitor checks every request
// against the queued descriptors and every status output against a small model.
module tb_eth_idma_desc_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        desc_valid_i = 1'b0, desc_ready_o;
    logic [31:0] desc_src_addr_i = '0, desc_dst_addr_i = '0, desc_length_i = '0;
    logic        desc_dir_i = 1'b0, desc_last_i = 1'b0, flush_i = 1'b0;
    logic        req_valid_o, req_ready_i = 1'b0;
    logic [31:0] req_src_addr_o, req_dst_addr_o, req_length_o;
    logic [2:0]  req_src_protocol_o, req_dst_protocol_o;
    logic        req_last_o;
    logic        rsp_valid_i = 1'b0, rsp_ready_o, rsp_error_i = 1'b0;
    logic        busy_o;
    logic [15:0] done_cnt_o;
    logic [7:0]  err_cnt_o;
    logic        zero_drop_o, irq_o;

    eth_idma_desc_queue dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i),
        .desc_length_i(desc_length_i), .desc_dir_i(desc_dir_i), .desc_last_i(desc_last_i),
        .flush_i(flush_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_src_addr_o(req_src_addr_o), .req_dst_addr_o(req_dst_addr_o),
        .req_length_o(req_length_o), .req_src_protocol_o(req_src_protocol_o),
        .req_dst_protocol_o(req_dst_protocol_o), .req_last_o(req_last_o),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
        .busy_o(busy_o), .done_cnt_o(done_cnt_o), .err_cnt_o(err_cnt_o),
        .zero_drop_o(zero_drop_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int           n_vec = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;
    bit           verbose = 1'b1;
    logic [102:0] exp_q [$];
    logic         tag_q [$];
    int           exp_out = 0;
    logic         exp_irq = 1'b0, exp_zero = 1'b0;
    logic [15:0]  exp_done = '0;
    logic [7:0]   exp_err = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: status checks reflect the previous edge; handshakes seen here update the model.
    logic         m_iss, m_ret, m_tag;
    logic [102:0] m_e;
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("desc_ready", desc_ready_o, (exp_q.size() < 4) && !flush_i);
            chk("req_valid", req_valid_o, (exp_q.size() != 0) && (exp_out < 2));
            chk("rsp_ready", rsp_ready_o, exp_out != 0);
            chk("busy", busy_o, (exp_q.size() != 0) || (exp_out != 0));
            chk("irq", irq_o, exp_irq);
            chk("done_cnt", done_cnt_o, exp_done);
            chk("err_cnt", err_cnt_o, exp_err);
            chk("zero_drop", zero_drop_o, exp_zero);
            m_iss = req_valid_o && req_ready_i;
            m_ret = rsp_valid_i && rsp_ready_o;
            if (m_iss) begin
                if (exp_q.size() == 0) begin
                    chk("req_spurious", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("req_fields", {req_src_addr_o, req_dst_addr_o, req_length_o,
                                       req_src_protocol_o, req_dst_protocol_o, req_last_o}, m_e);
                    tag_q.push_back(m_e[0]);
                    if (verbose)
                        $display("issue src=%h dst=%h len=%0d last=%b",
                                 req_src_addr_o, req_dst_addr_o, req_length_o, req_last_o);
                end
                exp_out++;
            end
            exp_irq = 1'b0;
            if (m_ret) begin
                m_tag = 1'b0;
                if (tag_q.size() == 0) chk("rsp_spurious", 1, 0);
                else m_tag = tag_q.pop_front();
                exp_irq = m_tag || rsp_error_i;
                if (rsp_error_i) begin
                    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                end else begin
                    exp_done = exp_done + 16'd1;
                end
                exp_out--;
                if (verbose) $display("retire err=%b last=%b", rsp_error_i, m_tag);
            end
        end
    end

    task automatic drive_cycle(input logic pv, input logic [31:0] src, input logic [31:0] dst,
                               input logic [31:0] len, input logic dir, input logic last,
                               input logic rr, input logic rv, input logic re, input logic fl,
                               output logic hs);
        logic         rv_s, iss_s;
        logic [102:0] e;
        desc_valid_i = pv; desc_src_addr_i = src; desc_dst_addr_i = dst;
        desc_length_i = len; desc_dir_i = dir; desc_last_i = last;
        req_ready_i = rr; rsp_valid_i = rv; rsp_error_i = re; flush_i = fl;
        #1;
        hs    = pv && desc_ready_o;
        rv_s  = req_valid_o;
        iss_s = req_valid_o && rr;
        @(posedge clk_i);
        if (fl) begin
            if (rv_s && !iss_s && exp_q.size() != 0) begin
                e = exp_q[0];
                exp_q.delete();
                exp_q.push_back(e);
            end else begin
                exp_q.delete();
            end
        end
        if (hs) begin
            if (len == 0) begin
                exp_zero = 1'b1;
            end else begin
                exp_q.push_back({src, dst, len, (dir ? 3'd7 : 3'd0), (dir ? 3'd0 : 3'd7), last});
                if (verbose) $display("push src=%h dst=%h len=%0d dir=%b last=%b", src, dst, len, dir, last);
            end
        end
        #1;
    endtask

    task automatic idle(input logic rr, input logic rv, input logic re);
        logic h;
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, rr, rv, re, 1'b0, h);
    endtask

    task automatic push(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                        input logic dir, input logic last);
        logic h;
        drive_cycle(1'b1, src, dst, len, dir, last, 1'b0, 1'b0, 1'b0, 1'b0, h);
    endtask

    task automatic drain(input logic re);
        for (int i = 0; i < 64 && (exp_q.size() != 0 || exp_out != 0); i++) idle(1'b1, 1'b1, re);
        idle(1'b0, 1'b0, 1'b0);
        chk("drain_busy", busy_o, 0);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        desc_valid_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
        rsp_error_i = 1'b0; flush_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_q.delete(); tag_q.delete();
        exp_out = 0; exp_irq = 1'b0; exp_zero = 1'b0; exp_done = '0; exp_err = '0;
        #1;
        chk("rst_desc_ready", desc_ready_o, 1);
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_rsp_ready", rsp_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_counts", {done_cnt_o, err_cnt_o, zero_drop_o, irq_o}, 0);
        chk("rst_req_data", {req_src_addr_o, req_dst_addr_o, req_length_o}, 0);
        mon_en = 1'b1;
    endtask

    logic [102:0] snap;
    logic         h;
    int           pushed;
    logic [15:0]  done_before;

    initial begin
        do_reset();

        // Single TX descriptor
        push(32'h1000, 32'h0, 32'd64, 1'b0, 1'b1);
        chk("t1_valid_lat", req_valid_o, 1);
        chk("t1_proto", {req_src_protocol_o, req_dst_protocol_o}, {3'd0, 3'd7});
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 1'b0);
        chk("t1_irq", irq_o, 1);
        chk("t1_done", done_cnt_o, 16'd1);
        chk("t1_busy", busy_o, 0);
        idle(1'b0, 1'b0, 1'b0);
        chk("t1_irq_end", irq_o, 0);

        // Backpressure: fill the queue, fields must hold while ready is low
        for (int i = 0; i < 4; i++)
            push(32'h2000 + 32'(i) * 32'h100, 32'h8000 + 32'(i), 32'd16 + 32'(i), i[0], i == 3);
        chk("bp_full", desc_ready_o, 0);
        snap = {req_src_addr_o, req_dst_addr_o, req_length_o,
                req_src_protocol_o, req_dst_protocol_o, req_last_o};
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0, 1'b0);
            chk("bp_stable", {req_src_addr_o, req_dst_addr_o, req_length_o,
                              req_src_protocol_o, req_dst_protocol_o, req_last_o}, snap);
        end
        drain(1'b0);

        // Outstanding limit
        for (int i = 0; i < 4; i++) push(32'h3000 + 32'(i), 32'h9000, 32'd8, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 1'b0);
        chk("ol_limit_valid", req_valid_o, 0);
        chk("ol_limit_rsp_ready", rsp_ready_o, 1);
        idle(1'b1, 1'b1, 1'b0);
        chk("ol_third_valid", req_valid_o, 1);
        idle(1'b1, 1'b1, 1'b0);
        chk("ol_swap_rsp_ready", rsp_ready_o, 1);
        drain(1'b0);

        // Error path
        done_before = exp_done;
        push(32'h4000, 32'h4400, 32'd32, 1'b1, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 1'b1);
        chk("err_cnt_one", err_cnt_o, 8'd1);
        chk("err_irq", irq_o, 1);
        chk("err_done_hold", done_cnt_o, done_before);
        verbose = 1'b0;
        for (int i = 0; i < 300; i++)
            drive_cycle(1'b1, 32'h5000, 32'h5100, 32'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, h);
        drain(1'b1);
        chk("err_sat", err_cnt_o, 8'd255);
        verbose = 1'b1;

        // Flush keeps the presented head, drops the rest, refuses a same-cycle push
        for (int i = 0; i < 3; i++) push(32'h6000 + 32'(i), 32'h6100, 32'd12, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h6fff, 32'h0, 32'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, h);
        chk("fl_push_refused", h, 0);
        chk("fl_head_kept", {req_valid_o, req_src_addr_o}, {1'b1, 32'h6000});
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        chk("fl_rest_gone", req_valid_o, 0);
        drain(1'b0);

        // Reset in the middle of traffic
        push(32'h7000, 32'h0, 32'd4, 1'b0, 1'b1);
        push(32'h7001, 32'h0, 32'd4, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 1'b0);
        do_reset();
        idle(1'b0, 1'b1, 1'b0);
        chk("rst_late_rsp", done_cnt_o, 16'd0);

        // Zero-length drop, then done counter wrap
        push(32'h8000, 32'h0, 32'd0, 1'b0, 1'b1);
        chk("zero_flag", zero_drop_o, 1);
        chk("zero_no_issue", req_valid_o, 0);
        verbose = 1'b0;
        pushed = 0;
        for (int i = 0; i < 70000 && pushed < 65537; i++) begin
            drive_cycle(1'b1, 32'h9000 + 32'(i), 32'ha000, 32'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, h);
            if (h) pushed++;
        end
        chk("wrap_pushed", pushed, 65537);
        drain(1'b0);
        chk("wrap_done", done_cnt_o, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
